sq_accum: RTL

- Upstream feeder for the integer square-root stage.
- Accepts a stream of signed samples over a valid/ready handshake and squares each one with a serial shift-add multiplier.
- Accumulates the squares into a saturating `MAX_NUM`-bit sum.
- On the sample flagged last, presents the sum (e.g. squared Euclidean norm) for the sqrt stage to consume.

---
 rtl/sq_accum.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sq_accum.sv
// Sum-of-squares front end for the integer square-root stage: squares signed samples
// with a serial shift-add multiplier and accumulates them into a saturating sum per frame.
`timescale 1ns/1ps
`ifndef MAX_NUM
`define MAX_NUM 21
`endif

module sq_accum #(
  parameter int DATA_W = 10,
  parameter int ACC_W  = `MAX_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE_D    = DATA_W'(1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic              in_ready_reg, in_ready_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] mcand_reg, mcand_next;
  logic [PROD_W-1:0] prod_reg, prod_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              last_reg, last_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic              sat_reg, sat_next;

  logic              accept;
  logic              take;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   step_sum;
  logic [PROD_W-1:0] prod_shifted;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]  acc_clamped;

  assign accept = in_valid && in_ready_reg && !clear;
  assign take   = out_valid_reg && out_ready && !clear;

  // Two's-complement negate; the most negative sample wraps to 2^(DATA_W-1), still exact unsigned.
  assign mag = in_data[DATA_W-1] ? (~in_data + ONE_D) : in_data;

  // Multiplier: low half of prod_reg holds the remaining multiplier bits, LSB first.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pp
    assign addend[gi] = mcand_reg[gi] & prod_reg[0];
  end

  assign step_sum     = {1'b0, prod_reg[PROD_W-1:DATA_W]} + {1'b0, addend};
  assign prod_shifted = {step_sum, prod_reg[DATA_W-1:1]};

  assign acc_sum     = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_reg};
  assign acc_clamped = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];

  // State and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (accept) state_next = S_MUL;
        S_MUL:  if (cnt_reg == CNT_LAST) state_next = S_ACC;
        S_ACC:  state_next = last_reg ? S_DONE : S_IDLE;
        S_DONE: if (take) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_next  = (state_next == S_IDLE);
    out_valid_next = (state_next == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg <= '0;
      prod_reg  <= '0;
      cnt_reg   <= '0;
      last_reg  <= 1'b0;
      acc_reg   <= '0;
      sat_reg   <= 1'b0;
    end else begin
      mcand_reg <= mcand_next;
      prod_reg  <= prod_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      acc_reg   <= acc_next;
      sat_reg   <= sat_next;
    end
  end

  always_comb begin
    mcand_next = mcand_reg;
    prod_next  = prod_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    acc_next   = acc_reg;
    sat_next   = sat_reg;
    if (clear) begin
      acc_next = '0;
      sat_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            mcand_next = mag;
            prod_next  = {{DATA_W{1'b0}}, mag};
            cnt_next   = '0;
            last_next  = in_last;
          end
        end
        S_MUL: begin
          prod_next = prod_shifted;
          cnt_next  = cnt_reg + CNT_ONE;
        end
        S_ACC: begin
          acc_next = acc_clamped;
          if (acc_sum[ACC_W]) sat_next = 1'b1;
        end
        S_DONE: begin
          if (take) begin
            acc_next = '0;
            sat_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_sum   = acc_reg;
  assign out_sat   = sat_reg;

endmodule
